// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared widths and FSM state encoding for the product accumulator
package mac_pkg;

  localparam int PROD_W = 32;
  localparam int ACC_W  = 40;
  localparam int LEN_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/acc_adder.sv
// rtl/acc_adder.sv - W-bit unsigned ripple adder with carry-out
module acc_adder #(
  parameter int W = 40
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         carry
);

  logic [W:0] c;

  assign c[0]  = 1'b0;
  assign carry = c[W];

  for (genvar i = 0; i < W; i++) begin : g_bit
    fa_cell u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end

endmodule

// File: rtl/fa_cell.sv
// rtl/fa_cell.sv - single-bit full adder cell
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - sums a programmed number of multiplier products
module product_accumulator #(
  parameter int PROD_W = mac_pkg::PROD_W,
  parameter int ACC_W  = mac_pkg::ACC_W,
  parameter int LEN_W  = mac_pkg::LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod,
  output logic              prod_ready,
  output logic              res_valid,
  output logic [ACC_W-1:0]  res,
  input  logic              res_ready,
  output logic              overflow,
  output logic              busy
);

  import mac_pkg::*;

  state_t             state, state_nx;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   prod_ext;
  logic [ACC_W-1:0]   sum;
  logic               carry;
  logic [LEN_W-1:0]   cnt;
  logic               ovf;
  logic               xfer;

  assign prod_ext = ACC_W'(prod);

  acc_adder #(.W(ACC_W)) u_adder (
    .a     (acc),
    .b     (prod_ext),
    .sum   (sum),
    .carry (carry)
  );

  // Handshake outputs depend on state only, never on the upstream valid
  assign prod_ready = (state == ST_ACC);
  assign res_valid  = (state == ST_DONE);
  assign busy       = (state != ST_IDLE);
  assign xfer       = prod_valid && prod_ready;
  assign res        = acc;
  assign overflow   = ovf;

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (start) state_nx = (len != '0) ? ST_ACC : ST_DONE;
      end
      ST_ACC: begin
        if (xfer && cnt == LEN_W'(1)) state_nx = ST_DONE;
      end
      ST_DONE: begin
        if (res_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE: begin
          if (start) begin
            acc <= '0;
            ovf <= 1'b0;
            cnt <= len;
          end
        end
        ST_ACC: begin
          if (xfer) begin
            acc <= sum;
            ovf <= ovf | carry;
            cnt <= cnt - LEN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
